// File: rtl/bitonic_seq_sorter.sv
// Sequential bitonic sorter: loads N words, sorts in place with one
// compare-exchange per clock, then streams the block out with valid/ready.
module bitonic_seq_sorter #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(IW + 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_buf [N];
  logic [IW-1:0]         r_wr_idx;
  logic [IW-1:0]         r_rd_idx;
  logic [IW-1:0]         r_i;
  logic [LW-1:0]         r_klg;
  logic [LW-1:0]         r_jlg;
  logic                  r_dir;

  logic [IW-1:0]         w_j;
  logic [IW:0]           w_k;
  logic [IW-1:0]         w_l;
  logic [IW-1:0]         w_inc;
  logic [IW-1:0]         w_next_i;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_up;
  logic                  w_swap;
  logic                  w_last_i;
  logic                  w_last_j;
  logic                  w_last_k;
  logic                  w_acc;
  logic                  w_out_hs;

  // Stage k and sub-stage j are kept as log2 exponents so no counter exceeds N-1.
  assign w_j      = IW'(1) << r_jlg;
  assign w_k      = (IW+1)'(1) << r_klg;
  assign w_l      = r_i ^ w_j;
  assign w_up     = ((({1'b0, r_i}) & w_k) == '0) ~^ r_dir;
  assign w_a      = r_buf[r_i];
  assign w_b      = r_buf[w_l];
  assign w_swap   = w_up ? (w_a > w_b) : (w_a < w_b);

  // Valid i have bit j clear; the largest such index is N-1-j == ~j.
  assign w_last_i = (r_i == ~w_j);
  assign w_last_j = (r_jlg == '0);
  assign w_last_k = (r_klg == LW'(IW));
  assign w_inc    = r_i + 1'b1;
  assign w_next_i = ((w_inc & w_j) != '0) ? (w_inc + w_j) : w_inc;

  assign in_ready  = (r_state == S_LOAD) && !rst;
  assign out_valid = (r_state == S_DRAIN) && !rst;
  assign busy      = (r_state != S_LOAD) && !rst;
  assign out_data  = out_valid ? r_buf[r_rd_idx] : '0;
  assign out_last  = out_valid && (r_rd_idx == IW'(N-1));

  assign w_acc    = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_i      <= '0;
      r_klg    <= '0;
      r_jlg    <= '0;
      r_dir    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc) begin
            if (r_wr_idx == '0) r_dir <= in_dir;
            if (r_wr_idx == IW'(N-1)) begin
              r_wr_idx <= '0;
              r_state  <= S_SORT;
              r_klg    <= LW'(1);
              r_jlg    <= '0;
              r_i      <= '0;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end
        S_SORT: begin
          if (w_last_i) begin
            r_i <= '0;
            if (w_last_j) begin
              if (w_last_k) begin
                r_state  <= S_DRAIN;
                r_rd_idx <= '0;
              end else begin
                // Next stage k*2 starts at j = old k.
                r_jlg <= r_klg;
                r_klg <= r_klg + 1'b1;
              end
            end else begin
              r_jlg <= r_jlg - 1'b1;
            end
          end else begin
            r_i <= w_next_i;
          end
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            if (r_rd_idx == IW'(N-1)) begin
              r_rd_idx <= '0;
              r_state  <= S_LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Buffer holds no reset: contents are meaningless outside a loaded block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_acc) begin
        r_buf[r_wr_idx] <= in_data;
      end else if ((r_state == S_SORT) && w_swap) begin
        r_buf[r_i] <= w_b;
        r_buf[w_l] <= w_a;
      end
    end
  end

endmodule
